rv32i_issue_scoreboard: RTL
===========================

Name: rv32i_issue_scoreboard

Overview:
- In-order issue controller between decode and execute for the RV32I pipeline.
- Tracks outstanding register writes per architectural register.
- Stalls any instruction with a RAW hazard on rs1/rs2, or whose rd counter is saturated.
- Drains the machine before SYSTEM, FENCE and undefined opcodes, and issues accepted instructions through a one-entry registered valid/ready stage.

Parameters:
- PENDING_MAX, 3: maximum outstanding writes tracked per register. Counter width is clog2(PENDING_MAX+1).
- XLEN, 32: instruction and data word width. Fixed for RV32; no other value is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  scoreboard accepts the instruction this cycle.
- in_inst  in  32  raw instruction word.
- out_valid  out  1  issued instruction valid toward execute.
- out_ready  in  1  execute accepts the issued instruction.
- out_inst  out  32  issued instruction word.
- wb_valid  in  1  writeback retires one register write.
- wb_rd  in  5  destination register of the retired write.
- busy  out  1  any pending counter non-zero, or out_valid.
- wb_error  out  1  sticky; set on writeback to a register whose pending counter is zero.

Behaviour:
- Reset (async, rst_n=0): all counters 0, state RUN, out_valid=0, out_inst=0, wb_error=0. in_ready is 0 while reset is asserted. Reset mid-stream discards the held instruction and all pending state.
- Register usage is decoded from opcode in_inst[6:0] and funct3 in_inst[14:12]:
  - OP: rs1, rs2, rd.
  - IMM, LOAD, JALR: rs1, rd.
  - STORE, BRANCH: rs1, rs2.
  - LUI, AUIPC, JAL: rd.
  - SYSTEM with funct3=0: no registers, serializing.
  - SYSTEM CSR forms: rd; rs1 only when funct3[2]=0; serializing.
  - FENCE and any other opcode: no registers, serializing.
- x0 is never pending: a use of register 0 never hazards and never increments. wb_rd=0 is ignored and does not set wb_error.
- hazard = (use_rs1 && cnt[rs1]!=0) || (use_rs2 && cnt[rs2]!=0) || (use_rd && cnt[rd]==PENDING_MAX).
- space = !out_valid || out_ready.
- FSM:
  - RUN, non-serializing instruction: in_ready = in_valid-independent (!hazard && space).
  - RUN, serializing instruction at input: if all counters are 0 and !out_valid, accept as normal with in_ready = space. Otherwise in_ready=0 and the next state is DRAIN.
  - DRAIN: in_ready=0. Return to RUN on the cycle when all counters are 0 and out_valid=0. The instruction is accepted no earlier than the following cycle.
- Accept (in_valid && in_ready) in cycle N: out_valid=1 and out_inst=in_inst in cycle N+1. Latency is one cycle.
- Back-to-back accepts give throughput of 1 instruction per cycle.
- The output handshake is held stable: out_inst does not change while out_valid && !out_ready.
- Counter update per cycle: +1 on cnt[rd] if accepted with use_rd and rd!=0; -1 on cnt[wb_rd] if wb_valid and wb_rd!=0.
  - Same register hit by both in one cycle: net unchanged.
  - Decrement of a zero counter: counter stays 0 and wb_error is set.
  - An increment beyond PENDING_MAX cannot occur, because the saturation check in hazard stalls it.
- The hazard check uses registered counter values; there is no same-cycle writeback bypass. A stall therefore releases in the cycle after the wb_valid that clears it.
- busy is combinational from registered state.

Decomposition:
- rv32i package additions:
  - typedef rv32i_reg_usage_t, a packed struct {use_rs1, use_rs2, use_rd, serialize}.
  - function rv32i_get_reg_usage(rv32_inst_t), reusing the existing opcode and funct3 enums.
  - typedef rv32i_issue_state_t, an enum {RV32I_ISSUE_RUN, RV32I_ISSUE_DRAIN}.
- Sub-module rv32i_pending_table: 32 saturating up/down counters. Provides the inc and dec ports, the x0 mask, two read ports plus an rd read port, an all_zero output and the underflow flag.

Test Plan:
- Independent stream: addi x1; addi x2; addi x3, all with out_ready=1 → accepted on 3 consecutive cycles, out_valid on cycles N+1..N+3, counts x1=x2=x3=1.
- RAW: addi x5,x0,1 then add x6,x5,x5 → second instruction stalls with in_ready=0 until wb_valid with wb_rd=5. in_ready rises the following cycle.
- x0 and saturation: with PENDING_MAX=3, four addi x7 with no writeback → the 4th stalls. Also lui x0 → no counter change and no stall.
- FENCE with x4 pending → state DRAIN, in_ready=0. On wb_rd=4 with out_valid=0, return to RUN, then FENCE is issued next cycle.
- Simultaneous events: accept addi x9 in the same cycle as wb_rd=9 while cnt[9]=1 → cnt[9] stays 1. A wb_rd=10 with cnt[10]=0 → wb_error=1, sticky.
- Reset mid-op: assert rst_n=0 with out_valid=1 and counters non-zero → out_valid, busy, wb_error and all counters go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv32i_issue_scoreboard_pkg.sv
// Shared RV32I decode types and register-usage lookup for the issue scoreboard.
package rv32i_issue_scoreboard_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [INST_W-1:0] rv32_inst_t;

    typedef enum logic [6:0] {
        RV32I_OP_LOAD   = 7'b0000011,
        RV32I_OP_FENCE  = 7'b0001111,
        RV32I_OP_IMM    = 7'b0010011,
        RV32I_OP_AUIPC  = 7'b0010111,
        RV32I_OP_STORE  = 7'b0100011,
        RV32I_OP_OP     = 7'b0110011,
        RV32I_OP_LUI    = 7'b0110111,
        RV32I_OP_BRANCH = 7'b1100011,
        RV32I_OP_JALR   = 7'b1100111,
        RV32I_OP_JAL    = 7'b1101111,
        RV32I_OP_SYSTEM = 7'b1110011
    } rv32i_opcode_t;

    typedef enum logic [2:0] {
        RV32I_F3_PRIV   = 3'b000,
        RV32I_F3_CSRRW  = 3'b001,
        RV32I_F3_CSRRS  = 3'b010,
        RV32I_F3_CSRRC  = 3'b011,
        RV32I_F3_CSRRWI = 3'b101,
        RV32I_F3_CSRRSI = 3'b110,
        RV32I_F3_CSRRCI = 3'b111
    } rv32i_sys_funct3_t;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic use_rd;
        logic serialize;
    } rv32i_reg_usage_t;

    typedef enum logic {
        RV32I_ISSUE_RUN   = 1'b0,
        RV32I_ISSUE_DRAIN = 1'b1
    } rv32i_issue_state_t;

    // Unknown opcodes and FENCE are treated as serializing with no register usage.
    function automatic rv32i_reg_usage_t rv32i_get_reg_usage(input rv32_inst_t inst);
        rv32i_reg_usage_t u;
        u = '0;
        case (inst[6:0])
            RV32I_OP_OP: begin
                u.use_rs1 = 1'b1;
                u.use_rs2 = 1'b1;
                u.use_rd  = 1'b1;
            end
            RV32I_OP_IMM, RV32I_OP_LOAD, RV32I_OP_JALR: begin
                u.use_rs1 = 1'b1;
                u.use_rd  = 1'b1;
            end
            RV32I_OP_STORE, RV32I_OP_BRANCH: begin
                u.use_rs1 = 1'b1;
                u.use_rs2 = 1'b1;
            end
            RV32I_OP_LUI, RV32I_OP_AUIPC, RV32I_OP_JAL: begin
                u.use_rd = 1'b1;
            end
            RV32I_OP_SYSTEM: begin
                u.serialize = 1'b1;
                if (inst[14:12] != RV32I_F3_PRIV) begin
                    u.use_rd  = 1'b1;
                    u.use_rs1 = ~inst[14];
                end
            end
            default: u.serialize = 1'b1;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/rv32i_pending_table.sv
// Per-register outstanding-write counters; x0 is hard-wired to zero pending.
module rv32i_pending_table
    import rv32i_issue_scoreboard_pkg::*;
#(
    parameter int unsigned PENDING_MAX = 3,
    localparam int unsigned CNT_W = $clog2(PENDING_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  logic [REG_W-1:0] inc_idx,
    input  logic             dec_en,
    input  logic [REG_W-1:0] dec_idx,
    input  logic [REG_W-1:0] rs1_idx,
    input  logic [REG_W-1:0] rs2_idx,
    input  logic [REG_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rs1_cnt,
    output logic [CNT_W-1:0] rs2_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             all_zero,
    output logic             underflow
);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_hit;
    logic [NUM_REGS-1:0] dec_hit;
    logic                any_pending;

    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        if (inc_en && inc_idx != '0) inc_hit[inc_idx] = 1'b1;
        if (dec_en && dec_idx != '0) dec_hit[dec_idx] = 1'b1;
    end

    // A simultaneous inc and dec on one register cancels out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (inc_hit[i] && !dec_hit[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (dec_hit[i] && !inc_hit[i] && cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        any_pending = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) any_pending = any_pending | (cnt[i] != '0);
    end

    assign all_zero  = ~any_pending;
    assign underflow = dec_en && (dec_idx != '0) && (cnt[dec_idx] == '0);
    assign rs1_cnt   = cnt[rs1_idx];
    assign rs2_cnt   = cnt[rs2_idx];
    assign rd_cnt    = cnt[rd_idx];

endmodule

// File: rtl/rv32i_issue_scoreboard.sv
// In-order RV32I issue stage: RAW/saturation stalls, drain before serializing ops.
module rv32i_issue_scoreboard
    import rv32i_issue_scoreboard_pkg::*;
#(
    parameter int unsigned PENDING_MAX = 3,
    parameter int unsigned XLEN        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_inst,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    output logic             busy,
    output logic             wb_error
);

    localparam int unsigned CNT_W = $clog2(PENDING_MAX + 1);

    rv32i_issue_state_t state;
    rv32i_reg_usage_t   usage_c;
    logic [CNT_W-1:0]   rs1_cnt;
    logic [CNT_W-1:0]   rs2_cnt;
    logic [CNT_W-1:0]   rd_cnt;
    logic               all_zero;
    logic               underflow_c;
    logic               hazard_c;
    logic               space_c;
    logic               idle_c;
    logic               accept_c;

    assign usage_c  = rv32i_get_reg_usage(in_inst);
    assign hazard_c = (usage_c.use_rs1 && rs1_cnt != '0) ||
                      (usage_c.use_rs2 && rs2_cnt != '0) ||
                      (usage_c.use_rd  && rd_cnt == CNT_W'(PENDING_MAX));
    assign space_c  = !out_valid || out_ready;
    assign idle_c   = all_zero && !out_valid;
    assign accept_c = in_valid && in_ready;
    assign busy     = !all_zero || out_valid;

    always_comb begin
        in_ready = 1'b0;
        if (rst_n && state == RV32I_ISSUE_RUN) begin
            if (usage_c.serialize) in_ready = idle_c && space_c;
            else                   in_ready = !hazard_c && space_c;
        end
    end

    rv32i_pending_table #(
        .PENDING_MAX (PENDING_MAX)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_en    (accept_c && usage_c.use_rd),
        .inc_idx   (in_inst[11:7]),
        .dec_en    (wb_valid),
        .dec_idx   (wb_rd),
        .rs1_idx   (in_inst[19:15]),
        .rs2_idx   (in_inst[24:20]),
        .rd_idx    (in_inst[11:7]),
        .rs1_cnt   (rs1_cnt),
        .rs2_cnt   (rs2_cnt),
        .rd_cnt    (rd_cnt),
        .all_zero  (all_zero),
        .underflow (underflow_c)
    );

    // Drain FSM, one-entry output register and sticky writeback error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RV32I_ISSUE_RUN;
            out_valid <= 1'b0;
            out_inst  <= '0;
            wb_error  <= 1'b0;
        end else begin
            case (state)
                RV32I_ISSUE_RUN:   if (in_valid && usage_c.serialize && !idle_c) state <= RV32I_ISSUE_DRAIN;
                RV32I_ISSUE_DRAIN: if (idle_c) state <= RV32I_ISSUE_RUN;
                default:           state <= RV32I_ISSUE_RUN;
            endcase
            if (accept_c) begin
                out_valid <= 1'b1;
                out_inst  <= in_inst;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (underflow_c) wb_error <= 1'b1;
        end
    end

endmodule
